// File: rtl/neuron_mac_seq.sv
// Sequential sign-magnitude neuron: one lane MAC per clock, then scale, optional ReLU, saturate.
// Latency: ready_signal rises N_INPUTS+1 edges after the accepting edge; accept-to-accept is N_INPUTS+3 cycles.
// Backpressure: none downstream; start_signal is only honoured in IDLE, ignored (not queued) while busy.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start_signal       request, sampled only in IDLE
//   relu_en            captured with start: 1 clamps negative results to +0
//   inputs, weights    N_INPUTS packed sign-magnitude lanes, lane i at [i*DATA_W +: DATA_W]
//   out                sign-magnitude result, held until the next result or reset
//   ready_signal       one-cycle pulse marking a new out value
//   busy               high from the accepting edge until the FSM returns to IDLE
module neuron_mac_seq #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8,
  parameter int SHIFT    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_signal,
  input  logic                         relu_en,
  input  logic [N_INPUTS*DATA_W-1:0]   inputs,
  input  logic [N_INPUTS*DATA_W-1:0]   weights,
  output logic [DATA_W-1:0]            out,
  output logic                         ready_signal,
  output logic                         busy
);

  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  // One guard bit per doubling of lanes plus a sign bit: the sum cannot overflow.
  localparam int ACC_W  = PROD_W + $clog2(N_INPUTS) + 1;
  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [ACC_W-1:0] MAG_MAX  = (ACC_W'(1) << MAG_W) - ACC_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ACT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] x_q [N_INPUTS];
  logic [DATA_W-1:0] w_q [N_INPUTS];
  logic              relu_q;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    ready_signal = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_signal) begin
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        busy = 1'b1;
        if (idx == IDX_LAST) begin
          state_nxt = S_ACT;
        end
      end
      S_ACT: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        ready_signal = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- lane product
  logic [DATA_W-1:0] cur_x, cur_w;
  logic [PROD_W-1:0] prod_mag;
  logic              prod_neg;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  prod_term;

  assign cur_x    = x_q[idx];
  assign cur_w    = w_q[idx];
  assign prod_mag = PROD_W'(cur_x[MAG_W-1:0]) * PROD_W'(cur_w[MAG_W-1:0]);
  // A zero magnitude (including negative-zero operands) always contributes +0.
  assign prod_neg  = (cur_x[DATA_W-1] ^ cur_w[DATA_W-1]) && (prod_mag != '0);
  assign prod_ext  = ACC_W'(prod_mag);
  assign prod_term = prod_neg ? (~prod_ext + ACC_W'(1)) : prod_ext;

  // ------------------------------------------------ scale / activate / clip
  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] scaled;
  logic                    scaled_neg;
  logic [ACC_W-1:0]        abs_val;
  logic [DATA_W-1:0]       result;

  assign acc_s      = acc;
  assign scaled     = acc_s >>> SHIFT;   // arithmetic shift floors toward -inf
  assign scaled_neg = scaled[ACC_W-1];
  assign abs_val    = scaled_neg ? $unsigned(-scaled) : $unsigned(scaled);

  always_comb begin
    result = '0;
    if (relu_q && scaled_neg) begin
      result = '0;
    end else if (abs_val > MAG_MAX) begin
      result = {scaled_neg, {MAG_W{1'b1}}};
    end else if (abs_val != '0) begin
      result = {scaled_neg, abs_val[MAG_W-1:0]};
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      out    <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_signal) begin
            // Operands are captured so the upstream layer is free to move on.
            for (int i = 0; i < N_INPUTS; i++) begin
              x_q[i] <= inputs[i*DATA_W +: DATA_W];
              w_q[i] <= weights[i*DATA_W +: DATA_W];
            end
            relu_q <= relu_en;
            acc    <= '0;
            idx    <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_term;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        S_ACT: begin
          out <= result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: two instances (SHIFT=0 and SHIFT=2) driven with the same
// directed operations; expected outputs are queued at issue and compared on ready_signal.
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_signal;
  logic        relu_en;
  logic [63:0] inputs;
  logic [63:0] weights;
  logic [7:0]  out_a, out_b;
  logic        ready_a, ready_b;
  logic        busy_a, busy_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  always #5 clk = ~clk;

  neuron_mac_seq #(.N_INPUTS(8), .DATA_W(8), .SHIFT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .relu_en      (relu_en),
    .inputs       (inputs),
    .weights      (weights),
    .out          (out_a),
    .ready_signal (ready_a),
    .busy         (busy_a)
  );

  neuron_mac_seq #(.N_INPUTS(8), .DATA_W(8), .SHIFT(2)) dut_s2 (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .relu_en      (relu_en),
    .inputs       (inputs),
    .weights      (weights),
    .out          (out_b),
    .ready_signal (ready_b),
    .busy         (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Issue one operation, scramble the buses after acceptance, wait for ready and score it.
  task automatic run_op(input string tag, input logic [63:0] xb, input logic [63:0] wb,
                        input logic relu, input logic [7:0] ea, input logic [7:0] eb,
                        input bit extra_start);
    int cyc;
    int extra_rdy;
    logic [7:0] exp_v;
    q_a.push_back(ea);
    q_b.push_back(eb);
    inputs       = xb;
    weights      = wb;
    relu_en      = relu;
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    inputs       = {$urandom, $urandom};
    weights      = {$urandom, $urandom};
    relu_en      = ~relu;
    check({tag, " busy_after_accept"}, busy_a, 1);
    cyc = 0;
    while (!ready_a && cyc < 40) begin
      start_signal = (extra_start && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start_signal = 1'b0;
    check({tag, " ready_latency"}, cyc, 9);
    check({tag, " ready_b_aligned"}, ready_b, 1);
    exp_v = q_a.pop_front();
    check({tag, " out_shift0"}, out_a, exp_v);
    exp_v = q_b.pop_front();
    check({tag, " out_shift2"}, out_b, exp_v);
    @(posedge clk); #1;
    check({tag, " ready_pulse_end"}, ready_a, 0);
    check({tag, " busy_a_end"}, busy_a, 0);
    check({tag, " busy_b_end"}, busy_b, 0);
    if (extra_start) begin
      extra_rdy = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (ready_a || ready_b || busy_a) extra_rdy++;
      end
      check({tag, " no_second_run"}, extra_rdy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  xs [8];
    logic [7:0]  ws [8];
    logic [63:0] xb, wb;
    int          rdy_cnt;

    rst          = 1'b1;
    start_signal = 1'b0;
    relu_en      = 1'b0;
    inputs       = '0;
    weights      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out_a, 0);
    check("reset ready", ready_a, 0);
    check("reset busy", busy_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sum 8 -> 0x08; scaled by 4 -> 0x02.
    run_op("t1 ones", fill(8'h01), fill(8'h01), 1'b0, 8'h08, 8'h02, 1'b0);
    // 8*127*127 = 129032 saturates in both scalings.
    run_op("t2 sat_pos", fill(8'h7F), fill(8'h7F), 1'b0, 8'h7F, 8'h7F, 1'b0);
    run_op("t2 sat_neg", fill(8'hFF), fill(8'h7F), 1'b0, 8'hFF, 8'hFF, 1'b0);
    // Sum -40 -> 0xA8; -40>>>2 = -10 -> 0x8A; ReLU clamps both to +0.
    run_op("t3 neg", fill(8'h81), fill(8'h05), 1'b0, 8'hA8, 8'h8A, 1'b0);
    run_op("t3 relu", fill(8'h81), fill(8'h05), 1'b1, 8'h00, 8'h00, 1'b0);

    // Mixed signs: 48-32-20+0+127-16-32+9 = 84 -> 0x54; 84>>>2 = 21 -> 0x15.
    xs = '{8'h10, 8'h90, 8'h05, 8'h00, 8'h7F, 8'h81, 8'h02, 8'h83};
    ws = '{8'h03, 8'h02, 8'h84, 8'h7F, 8'h01, 8'h10, 8'h90, 8'h83};
    for (int i = 0; i < 8; i++) begin
      xb[i*8 +: 8] = xs[i];
      wb[i*8 +: 8] = ws[i];
    end
    run_op("mixed", xb, wb, 1'b1, 8'h54, 8'h15, 1'b0);

    // -41 -> 0xA9; floor(-41/4) = -11 -> 0x8B.
    run_op("t4 floor", {56'h0, 8'h81}, {{7{8'h05}}, 8'h29}, 1'b0, 8'hA9, 8'h8B, 1'b0);

    // Abort in the middle of MAC: out (currently non-zero) must clear, no ready.
    inputs       = fill(8'h03);
    weights      = fill(8'h82);
    relu_en      = 1'b0;
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6 rst out_a", out_a, 0);
    check("t6 rst out_b", out_b, 0);
    check("t6 rst busy", busy_a, 0);
    check("t6 rst ready", ready_a, 0);
    rst = 1'b0;
    rdy_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ready_a || ready_b) rdy_cnt++;
    end
    check("t6 no_ready_after_abort", rdy_cnt, 0);
    // 8*(3*-2) = -48 -> 0xB0; -12 -> 0x8C.
    run_op("t6 fresh", fill(8'h03), fill(8'h82), 1'b0, 8'hB0, 8'h8C, 1'b0);

    // Negative-zero inputs give +0; a start pulse while busy is dropped.
    run_op("t5 negzero", fill(8'h80), fill(8'h7F), 1'b0, 8'h00, 8'h00, 1'b1);

    check("scoreboard drained", q_a.size() + q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
